// File: rtl/ats21_pkg.sv
// Shared ATS21 definitions: opcode encodings, issuer FSM states and the
// same-target conflict rule that decides whether A and B may share a transaction.
package ats21_pkg;

  localparam logic [2:0] OP_NOP     = 3'b000;
  localparam logic [2:0] OP_SET_CLK = 3'b001;
  localparam logic [2:0] OP_ADJ_CLK = 3'b010;
  localparam logic [2:0] OP_RD_CLK  = 3'b011;
  localparam logic [2:0] OP_RD_ALM  = 3'b100;
  localparam logic [2:0] OP_SET_ALM = 3'b101;
  localparam logic [2:0] OP_CLR_ALM = 3'b110;
  localparam logic [2:0] OP_MODE    = 3'b111;

  localparam logic [31:0] NOP_CMD = 32'h0;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REQ       = 3'd1,
    ST_HI        = 3'd2,
    ST_LO        = 3'd3,
    ST_WAIT_STAT = 3'd4
  } state_e;

  // Clock ops address a clock in [28:25]; alarm/mode ops address [28:24].
  // Set-alarm and clear-alarm on the same alarm also collide.
  function automatic logic cmd_conflict(input logic [31:0] a, input logic [31:0] b);
    logic [2:0] op_a;
    logic [2:0] op_b;
    logic       hit;
    op_a = a[31:29];
    op_b = b[31:29];
    hit  = 1'b0;
    if (op_a == op_b) begin
      case (op_a)
        OP_SET_CLK, OP_ADJ_CLK:          hit = (a[28:25] == b[28:25]);
        OP_SET_ALM, OP_CLR_ALM, OP_MODE: hit = (a[28:24] == b[28:24]);
        default:                         hit = 1'b0;
      endcase
    end else if ((op_a == OP_SET_ALM && op_b == OP_CLR_ALM) ||
                 (op_a == OP_CLR_ALM && op_b == OP_SET_ALM)) begin
      hit = (a[28:24] == b[28:24]);
    end
    return hit;
  endfunction

endpackage

// File: rtl/ats21_cmd_fifo.sv
// Synchronous command FIFO; the head word is visible combinationally so a pop
// and its data are taken in the same cycle. ready_o is registered (0 in reset).
module ats21_cmd_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk_1x,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             ready_o,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             not_full_q;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push_i && not_full_q;
  assign pop_ok  = pop_i && (count_q != '0);

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + CW'(1);
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_1x or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      not_full_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      not_full_q <= (count_d != CW'(DEPTH));
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk_1x) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign ready_o = not_full_q;

endmodule

// File: rtl/ats21_cmd_issuer.sv
// ATS21 host transmitter: bundles client A/B commands into one device transaction,
// sends upper then lower half-words, returns per-client Ack/Nack, latches alarm edges.
//
// state        | meaning
// ST_IDLE      | wait for a queued command; pop A and (if no conflict) B
// ST_REQ       | one-cycle dev_req strobe, half-words held at 0
// ST_HI        | upper halves driven; wait dev_ready up to RDY_TIMEOUT cycles
// ST_LO        | lower halves driven for one cycle
// ST_WAIT_STAT | let dev_stat settle STAT_DELAY cycles, then report responses
module ats21_cmd_issuer
  import ats21_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int RDY_TIMEOUT = 8,
  parameter int STAT_DELAY  = 2,
  parameter int NUM_ALARMS  = 24
) (
  input  logic                  clk_1x,
  input  logic                  reset,
  input  logic                  a_cmd_valid,
  output logic                  a_cmd_ready,
  input  logic [31:0]           a_cmd,
  input  logic                  b_cmd_valid,
  output logic                  b_cmd_ready,
  input  logic [31:0]           b_cmd,
  output logic                  a_rsp_valid,
  output logic                  a_rsp_ack,
  output logic                  b_rsp_valid,
  output logic                  b_rsp_ack,
  output logic                  dev_req,
  input  logic                  dev_ready,
  output logic [15:0]           dev_ctrlA,
  output logic [15:0]           dev_ctrlB,
  input  logic [1:0]            dev_stat,
  input  logic [NUM_ALARMS-1:0] dev_data,
  output logic [NUM_ALARMS-1:0] alarm_pending,
  input  logic [NUM_ALARMS-1:0] alarm_clr,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int TMR_MAX = (RDY_TIMEOUT > STAT_DELAY) ? RDY_TIMEOUT : STAT_DELAY;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [31:0]        cmd_a_q, cmd_a_d;
  logic [31:0]        cmd_b_q, cmd_b_d;
  logic               va_q, va_d;
  logic               vb_q, vb_d;
  logic               a_rsp_valid_q, a_rsp_valid_d;
  logic               a_rsp_ack_q, a_rsp_ack_d;
  logic               b_rsp_valid_q, b_rsp_valid_d;
  logic               b_rsp_ack_q, b_rsp_ack_d;
  logic               tmo_q, tmo_d;
  logic [NUM_ALARMS-1:0] data_dly_q;
  logic [NUM_ALARMS-1:0] pend_q, pend_d;

  logic        pop_a, pop_b;
  logic        empty_a, empty_b;
  logic [31:0] head_a, head_b;

  ats21_cmd_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo_a (
    .clk_1x  (clk_1x),
    .reset   (reset),
    .push_i  (a_cmd_valid),
    .wdata_i (a_cmd),
    .ready_o (a_cmd_ready),
    .pop_i   (pop_a),
    .rdata_o (head_a),
    .empty_o (empty_a)
  );

  ats21_cmd_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo_b (
    .clk_1x  (clk_1x),
    .reset   (reset),
    .push_i  (b_cmd_valid),
    .wdata_i (b_cmd),
    .ready_o (b_cmd_ready),
    .pop_i   (pop_b),
    .rdata_o (head_b),
    .empty_o (empty_b)
  );

  always_comb begin
    state_d       = state_q;
    tmr_d         = tmr_q;
    cmd_a_d       = cmd_a_q;
    cmd_b_d       = cmd_b_q;
    va_d          = va_q;
    vb_d          = vb_q;
    tmo_d         = tmo_q;
    pop_a         = 1'b0;
    pop_b         = 1'b0;
    a_rsp_valid_d = 1'b0;
    a_rsp_ack_d   = 1'b0;
    b_rsp_valid_d = 1'b0;
    b_rsp_ack_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty_a || !empty_b) begin
          pop_a   = !empty_a;
          // A conflicting B stays queued and rides the next transaction.
          pop_b   = !empty_b && !(!empty_a && cmd_conflict(head_a, head_b));
          va_d    = pop_a;
          vb_d    = pop_b;
          cmd_a_d = pop_a ? head_a : NOP_CMD;
          cmd_b_d = pop_b ? head_b : NOP_CMD;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        tmr_d   = TMR_W'(RDY_TIMEOUT - 1);
        state_d = ST_HI;
      end
      ST_HI: begin
        if (dev_ready) begin
          state_d = ST_LO;
        end else if (tmr_q == '0) begin
          tmo_d         = 1'b1;
          a_rsp_valid_d = va_q;
          b_rsp_valid_d = vb_q;
          state_d       = ST_IDLE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_LO: begin
        tmr_d   = TMR_W'(STAT_DELAY - 1);
        state_d = ST_WAIT_STAT;
      end
      ST_WAIT_STAT: begin
        if (tmr_q == '0) begin
          a_rsp_valid_d = va_q;
          a_rsp_ack_d   = va_q & dev_stat[0];
          b_rsp_valid_d = vb_q;
          b_rsp_ack_d   = vb_q & dev_stat[1];
          state_d       = ST_IDLE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_1x or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      tmr_q         <= '0;
      cmd_a_q       <= NOP_CMD;
      cmd_b_q       <= NOP_CMD;
      va_q          <= 1'b0;
      vb_q          <= 1'b0;
      tmo_q         <= 1'b0;
      a_rsp_valid_q <= 1'b0;
      a_rsp_ack_q   <= 1'b0;
      b_rsp_valid_q <= 1'b0;
      b_rsp_ack_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      tmr_q         <= tmr_d;
      cmd_a_q       <= cmd_a_d;
      cmd_b_q       <= cmd_b_d;
      va_q          <= va_d;
      vb_q          <= vb_d;
      tmo_q         <= tmo_d;
      a_rsp_valid_q <= a_rsp_valid_d;
      a_rsp_ack_q   <= a_rsp_ack_d;
      b_rsp_valid_q <= b_rsp_valid_d;
      b_rsp_ack_q   <= b_rsp_ack_d;
    end
  end

  always_comb begin
    dev_req   = 1'b0;
    dev_ctrlA = 16'h0;
    dev_ctrlB = 16'h0;
    case (state_q)
      ST_REQ: dev_req = 1'b1;
      ST_HI: begin
        dev_ctrlA = cmd_a_q[31:16];
        dev_ctrlB = cmd_b_q[31:16];
      end
      ST_LO: begin
        dev_ctrlA = cmd_a_q[15:0];
        dev_ctrlB = cmd_b_q[15:0];
      end
      default: ;
    endcase
  end

  // A fresh rising edge beats a same-cycle clear so no event is lost.
  always_comb begin
    pend_d = (pend_q & ~alarm_clr) | (dev_data & ~data_dly_q);
  end

  always_ff @(posedge clk_1x or posedge reset) begin
    if (reset) begin
      data_dly_q <= '0;
      pend_q     <= '0;
    end else begin
      data_dly_q <= dev_data;
      pend_q     <= pend_d;
    end
  end

  assign a_rsp_valid   = a_rsp_valid_q;
  assign a_rsp_ack     = a_rsp_ack_q;
  assign b_rsp_valid   = b_rsp_valid_q;
  assign b_rsp_ack     = b_rsp_ack_q;
  assign alarm_pending = pend_q;
  assign busy          = (state_q != ST_IDLE);
  assign timeout_err   = tmo_q;

endmodule

// File: tb/tb_ats21_cmd_issuer.sv
// Directed bench for ats21_cmd_issuer: hand-computed transactions, latencies,
// timeout, FIFO back-pressure, alarm edge capture and mid-transaction reset.
module tb_ats21_cmd_issuer;

  logic        clk_1x = 1'b0;
  logic        reset;
  logic        a_cmd_valid, b_cmd_valid;
  logic        a_cmd_ready, b_cmd_ready;
  logic [31:0] a_cmd, b_cmd;
  logic        a_rsp_valid, a_rsp_ack, b_rsp_valid, b_rsp_ack;
  logic        dev_req, dev_ready;
  logic [15:0] dev_ctrlA, dev_ctrlB;
  logic [1:0]  dev_stat;
  logic [23:0] dev_data, alarm_pending, alarm_clr;
  logic        busy, timeout_err;

  int n_chk = 0;
  int n_err = 0;

  logic        log_en = 1'b1;
  logic [63:0] log_q[$];
  time         a_t[$], b_t[$];
  bit          a_k[$], b_k[$];
  time         push_t;

  ats21_cmd_issuer dut (
    .clk_1x(clk_1x), .reset(reset),
    .a_cmd_valid(a_cmd_valid), .a_cmd_ready(a_cmd_ready), .a_cmd(a_cmd),
    .b_cmd_valid(b_cmd_valid), .b_cmd_ready(b_cmd_ready), .b_cmd(b_cmd),
    .a_rsp_valid(a_rsp_valid), .a_rsp_ack(a_rsp_ack),
    .b_rsp_valid(b_rsp_valid), .b_rsp_ack(b_rsp_ack),
    .dev_req(dev_req), .dev_ready(dev_ready),
    .dev_ctrlA(dev_ctrlA), .dev_ctrlB(dev_ctrlB),
    .dev_stat(dev_stat), .dev_data(dev_data),
    .alarm_pending(alarm_pending), .alarm_clr(alarm_clr),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk_1x = ~clk_1x;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] log_at(input int i);
    return (i < log_q.size()) ? log_q[i] : 64'hx;
  endfunction
  function automatic time at_a(input int i);
    return (i < a_t.size()) ? a_t[i] : 0;
  endfunction
  function automatic time at_b(input int i);
    return (i < b_t.size()) ? b_t[i] : 0;
  endfunction
  function automatic logic ack_a(input int i);
    return (i < a_k.size()) ? a_k[i] : 1'bx;
  endfunction
  function automatic logic ack_b(input int i);
    return (i < b_k.size()) ? b_k[i] : 1'bx;
  endfunction
  function automatic int cnt(input int which);
    case (which)
      0:       return a_t.size();
      1:       return b_t.size();
      default: return log_q.size();
    endcase
  endfunction

  // which: 0 = A responses, 1 = B responses, 2 = logged transactions
  task automatic wait_cnt(input int which, input int n);
    int k = 0;
    while (cnt(which) < n && k < 200) begin
      @(negedge clk_1x);
      k++;
    end
    if (cnt(which) < n) chk($sformatf("wait_cnt%0d", which), cnt(which), n);
  endtask

  task automatic wait_idle();
    int k = 0;
    repeat (3) @(negedge clk_1x);
    while (busy && k < 200) begin
      @(negedge clk_1x);
      k++;
    end
    if (busy) chk("wait_idle", busy, 0);
    repeat (2) @(negedge clk_1x);
  endtask

  task automatic push_a(input logic [31:0] c);
    int k = 0;
    @(negedge clk_1x);
    a_cmd_valid = 1'b1;
    a_cmd       = c;
    while (!a_cmd_ready && k < 100) begin
      @(negedge clk_1x);
      k++;
    end
    if (!a_cmd_ready) chk("push_a_ready", a_cmd_ready, 1);
    @(posedge clk_1x);
    push_t = $time;
    #1 a_cmd_valid = 1'b0;
  endtask

  task automatic push_ab(input logic [31:0] ca, input logic [31:0] cb);
    @(negedge clk_1x);
    a_cmd_valid = 1'b1; a_cmd = ca;
    b_cmd_valid = 1'b1; b_cmd = cb;
    @(posedge clk_1x);
    push_t = $time;
    #1;
    a_cmd_valid = 1'b0;
    b_cmd_valid = 1'b0;
  endtask

  // Transaction logger (valid while dev_ready answers in the first HI cycle)
  // and response recorder.
  initial begin : monitor
    logic        prev_req;
    logic        hi_seen;
    logic [15:0] up_a, up_b;
    prev_req = 1'b0;
    hi_seen  = 1'b0;
    up_a     = '0;
    up_b     = '0;
    forever begin
      @(negedge clk_1x);
      if (a_rsp_valid) begin a_t.push_back($time); a_k.push_back(a_rsp_ack); end
      if (b_rsp_valid) begin b_t.push_back($time); b_k.push_back(b_rsp_ack); end
      if (reset || !log_en) begin
        prev_req = 1'b0;
        hi_seen  = 1'b0;
      end else begin
        if (hi_seen) begin
          log_q.push_back({up_a, dev_ctrlA, up_b, dev_ctrlB});
          hi_seen = 1'b0;
        end
        if (prev_req) begin
          up_a    = dev_ctrlA;
          up_b    = dev_ctrlB;
          hi_seen = 1'b1;
        end
        if (dev_req) chk("req_ctrl_zero", {dev_ctrlA, dev_ctrlB}, 32'h0);
        prev_req = dev_req;
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int n0, na, nb;
    logic [31:0] c5 [6];
    reset       = 1'b1;
    a_cmd_valid = 1'b0; a_cmd = '0;
    b_cmd_valid = 1'b0; b_cmd = '0;
    dev_ready   = 1'b1;
    dev_stat    = 2'b00;
    dev_data    = '0;
    alarm_clr   = '0;

    // reset state
    repeat (3) @(negedge clk_1x);
    chk("rst_ready", {a_cmd_ready, b_cmd_ready}, 2'b00);
    chk("rst_req", dev_req, 0);
    chk("rst_ctrl", {dev_ctrlA, dev_ctrlB}, 32'h0);
    chk("rst_rsp", {a_rsp_valid, b_rsp_valid}, 2'b00);
    chk("rst_alarm", alarm_pending, 24'h0);
    chk("rst_flags", {busy, timeout_err}, 2'b00);
    reset = 1'b0;
    @(negedge clk_1x);
    chk("ready_after_rst", {a_cmd_ready, b_cmd_ready}, 2'b11);

    // A alone, device ready on first HI cycle
    dev_stat = 2'b01;
    n0 = log_q.size(); na = a_t.size(); nb = b_t.size();
    push_a(32'h2600_0010);
    wait_cnt(0, na + 1);
    chk("t1_latency", (at_a(na) - push_t) / 10, 6);
    chk("t1_ack", ack_a(na), 1);
    wait_idle();
    chk("t1_words", log_at(n0), 64'h2600_0010_0000_0000);
    chk("t1_no_b_rsp", b_t.size(), nb);

    // A and B bundled into one transaction
    dev_stat = 2'b11;
    n0 = log_q.size(); na = a_t.size(); nb = b_t.size();
    push_ab(32'h3200_0000, 32'h3400_0005);
    wait_cnt(1, nb + 1);
    wait_idle();
    chk("t2_words", log_at(n0), 64'h3200_0000_3400_0005);
    chk("t2_one_txn", log_q.size(), n0 + 1);
    chk("t2_same_cycle", at_b(nb), at_a(na));
    chk("t2_acks", {ack_a(na), ack_b(nb)}, 2'b11);

    // same alarm from both clients: A first, B in the following transaction
    n0 = log_q.size(); na = a_t.size(); nb = b_t.size();
    push_ab(32'hA100_0020, 32'hC100_0030);
    wait_cnt(1, nb + 1);
    wait_idle();
    chk("t3_first", log_at(n0), 64'hA100_0020_0000_0000);
    chk("t3_second", log_at(n0 + 1), 64'h0000_0000_C100_0030);
    chk("t3_b_after_a", at_b(nb) - at_a(na), 60);
    chk("t3_b_ack", ack_b(nb), 1);

    // ready timeout, then normal issue resumes
    dev_stat  = 2'b01;
    dev_ready = 1'b0;
    log_en    = 1'b0;
    na = a_t.size();
    push_a(32'h2600_0011);
    wait_cnt(0, na + 1);
    chk("t4_latency", (at_a(na) - push_t) / 10, 10);
    chk("t4_nack", ack_a(na), 0);
    chk("t4_tmo", timeout_err, 1);
    wait_idle();
    dev_ready = 1'b1;
    log_en    = 1'b1;
    n0 = log_q.size(); na = a_t.size();
    push_a(32'h4100_0002);
    wait_cnt(0, na + 1);
    wait_idle();
    chk("t4_next_words", log_at(n0), 64'h4100_0002_0000_0000);
    chk("t4_next_ack", ack_a(na), 1);
    chk("t4_tmo_sticky", timeout_err, 1);

    // FIFO fill while the FSM is busy; everything issued in order
    for (int i = 0; i < 6; i++) c5[i] = 32'h6100_0000 + i;
    n0 = log_q.size();
    for (int i = 0; i < 5; i++) push_a(c5[i]);
    chk("t5_full", a_cmd_ready, 0);
    push_a(c5[5]);
    wait_cnt(2, n0 + 6);
    wait_idle();
    for (int i = 0; i < 6; i++) chk($sformatf("t5_order%0d", i), log_at(n0 + i), {c5[i], 32'h0});

    // alarm edges
    @(negedge clk_1x); dev_data[3] = 1'b1;
    @(negedge clk_1x); chk("al_set", alarm_pending, 24'h000008);
    @(negedge clk_1x); chk("al_held_once", alarm_pending, 24'h000008);
    dev_data[3] = 1'b0; alarm_clr[3] = 1'b1;
    @(negedge clk_1x); alarm_clr[3] = 1'b0;
    chk("al_clr", alarm_pending, 24'h0);
    @(negedge clk_1x); chk("al_stay_clr", alarm_pending, 24'h0);
    dev_data[5] = 1'b1;
    @(negedge clk_1x); chk("al5_set", alarm_pending, 24'h000020);
    alarm_clr[5] = 1'b1;
    @(negedge clk_1x); alarm_clr[5] = 1'b0;
    @(negedge clk_1x); chk("al5_held_no_reset", alarm_pending, 24'h0);
    dev_data[5] = 1'b0;
    dev_data[7] = 1'b1; alarm_clr[7] = 1'b1;
    @(negedge clk_1x); alarm_clr[7] = 1'b0; dev_data[7] = 1'b0;
    chk("al_set_wins", alarm_pending, 24'h000080);

    // reset while in LO
    na = a_t.size();
    push_a(32'h2600_0099);
    repeat (3) @(posedge clk_1x);
    #2;
    chk("t7_in_lo", dev_ctrlA, 16'h0099);
    reset = 1'b1;
    #1;
    chk("t7_req", dev_req, 0);
    chk("t7_ctrl", {dev_ctrlA, dev_ctrlB}, 32'h0);
    chk("t7_busy", busy, 0);
    chk("t7_alarm", alarm_pending, 24'h0);
    chk("t7_tmo", timeout_err, 0);
    repeat (3) @(negedge clk_1x);
    reset = 1'b0;
    repeat (12) @(negedge clk_1x);
    chk("t7_no_rsp", a_t.size(), na);
    chk("t7_ready", {a_cmd_ready, busy}, 2'b10);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
